// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the MIPS-subset datapath.
// Steps the latched instruction through IF/ID/EX/MEM/WB, drives the stage
// strobes and PC write, handshakes with data memory, and traps illegal
// opcodes and memory timeouts in a sticky error state.
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ins,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic [2:0]       op,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Mem2Reg,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_e;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2b;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_J    = 6'h02;

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic       is_r, is_lw, is_sw, is_beq, is_addi, is_j;
    logic       r_legal, legal, wait_last;
    logic [2:0] r_op;
    logic       unused_ir;

    // Only opcode and funct steer the sequencer; the operand fields belong to the datapath.
    assign unused_ir = ^ir_q[25:6];

    // Instruction class decode from the latched instruction
    always_comb begin
        is_r    = (ir_q[31:26] == OPC_R);
        is_lw   = (ir_q[31:26] == OPC_LW);
        is_sw   = (ir_q[31:26] == OPC_SW);
        is_beq  = (ir_q[31:26] == OPC_BEQ);
        is_addi = (ir_q[31:26] == OPC_ADDI);
        is_j    = (ir_q[31:26] == OPC_J);
        r_legal = 1'b1;
        r_op    = 3'b010;
        case (ir_q[5:0])
            6'h20:   r_op = 3'b010;
            6'h22:   r_op = 3'b110;
            6'h24:   r_op = 3'b000;
            6'h25:   r_op = 3'b001;
            6'h2a:   r_op = 3'b111;
            default: r_legal = 1'b0;
        endcase
        legal = (is_r & r_legal) | is_lw | is_sw | is_beq | is_addi | is_j;
    end

    assign wait_last = (wait_q == WAIT_W'(WAIT_MAX - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID:  state_d = legal ? S_EX : S_ERR;
            S_EX: begin
                if (is_beq || is_j)     state_d = S_IF;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready)      state_d = is_sw ? S_IF : S_WB;
                else if (wait_last) state_d = S_ERR;
                else                state_d = S_MEM;
            end
            S_WB:  state_d = S_IF;
            S_ERR: state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    // Moore stage controls; the only input-dependent terms are the beq target and sw completion
    always_comb begin
        pc_we    = 1'b0;
        pc_src   = 2'b00;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        op       = 3'b000;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Mem2Reg  = 1'b0;
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            RegDst = is_r;
            ALUSrc = is_lw | is_sw | is_addi;
            if (is_r)                           op = r_op;
            else if (is_beq)                    op = 3'b110;
            else if (is_lw || is_sw || is_addi) op = 3'b010;
            else                                op = 3'b000;
        end
        case (state_q)
            S_EX: begin
                if (is_beq) begin
                    pc_we  = 1'b1;
                    pc_src = zero ? 2'b01 : 2'b00;
                end else if (is_j) begin
                    pc_we  = 1'b1;
                    pc_src = 2'b10;
                end
            end
            S_MEM: begin
                MemRead  = is_lw;
                MemWrite = is_sw;
                pc_we    = is_sw & mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                pc_we    = 1'b1;
                Mem2Reg  = is_lw;
            end
            default: ;
        endcase
        state     = state_q;
        err       = (state_q == S_ERR);
        instr_cnt = cnt_q;
    end

    // Instruction latch, memory wait counter and retired-instruction counter
    always_comb begin
        ir_d   = (state_q == S_IF) ? ins : ir_q;
        wait_d = (state_q == S_MEM && !mem_ready) ? wait_q + WAIT_W'(1) : '0;
        cnt_d  = pc_we ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q   <= '0;
            wait_q <= '0;
            cnt_q  <= '0;
        end else begin
            ir_q   <= ir_d;
            wait_q <= wait_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins;
    logic        zero;
    logic        mem_ready;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, err;
    logic [2:0]  op;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ins       (ins),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .RegDst    (RegDst),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .op        (op),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Mem2Reg   (Mem2Reg),
        .state     (state),
        .err       (err),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // R-type or addi through IF/ID/EX/WB, checking WB controls
    task automatic run_alu(input logic [31:0] word, input logic [2:0] exp_op,
                           input logic exp_src, input logic exp_dst, input logic [31:0] exp_cnt);
        ins = word;
        step();
        ins = 32'hFFFF_FFFF;
        check("alu_id_state", 32'(state), 32'd1);
        step();
        check("alu_ex_state", 32'(state), 32'd2);
        check("alu_ex_pcwe", 32'(pc_we), 32'd0);
        step();
        check("alu_wb_state", 32'(state), 32'd4);
        check("alu_wb_op", 32'(op), 32'(exp_op));
        check("alu_wb_alusrc", 32'(ALUSrc), 32'(exp_src));
        check("alu_wb_regdst", 32'(RegDst), 32'(exp_dst));
        check("alu_wb_regwrite", 32'(RegWrite), 32'd1);
        check("alu_wb_pcwe", 32'(pc_we), 32'd1);
        check("alu_wb_mem2reg", 32'(Mem2Reg), 32'd0);
        step();
        check("alu_if_state", 32'(state), 32'd0);
        check("alu_cnt", instr_cnt, exp_cnt);
    endtask

    // beq or j: three clocks, PC write in EX only
    task automatic run_branch(input logic [31:0] word, input logic z,
                              input logic [1:0] exp_src, input logic [31:0] exp_cnt);
        ins = word;
        step();
        ins = 32'h0;
        step();
        zero = z;
        #1;
        check("br_ex_state", 32'(state), 32'd2);
        check("br_ex_pcwe", 32'(pc_we), 32'd1);
        check("br_ex_pcsrc", 32'(pc_src), 32'(exp_src));
        check("br_ex_regwrite", 32'(RegWrite), 32'd0);
        step();
        zero = ~z;
        check("br_if_state", 32'(state), 32'd0);
        check("br_if_pcwe", 32'(pc_we), 32'd0);
        check("br_cnt", instr_cnt, exp_cnt);
    endtask

    initial begin
        int lat;
        int hi;
        int bad;
        ins = 32'h0;
        zero = 1'b0;
        mem_ready = 1'b0;
        do_reset();

        check("rst_state", 32'(state), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", instr_cnt, 32'd0);
        check("rst_strobes", 32'({pc_we, RegWrite, MemRead, MemWrite}), 32'd0);

        // add $3,$1,$2 ; sub ; slt ; addi
        run_alu(32'h0022_1820, 3'b010, 1'b0, 1'b1, 32'd1);
        run_alu(32'h0022_1822, 3'b110, 1'b0, 1'b1, 32'd2);
        run_alu(32'h0022_182A, 3'b111, 1'b0, 1'b1, 32'd3);
        run_alu(32'h2022_0005, 3'b010, 1'b1, 1'b0, 32'd4);

        // lw with mem_ready low for 3 cycles
        lat = 0;
        ins = 32'h8C22_0004;
        step(); lat++;
        step(); lat++;
        check("lw_ex_alusrc", 32'(ALUSrc), 32'd1);
        mem_ready = 1'b0;
        step(); lat++;
        hi = 0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #1;
            if (MemRead) hi++;
            if (pc_we || state != 3'd3) bad++;
            step(); lat++;
        end
        mem_ready = 1'b0;
        check("lw_memread_cycles", 32'(hi), 32'd4);
        check("lw_mem_nopcwe", 32'(bad), 32'd0);
        check("lw_wb_state", 32'(state), 32'd4);
        check("lw_wb_mem2reg", 32'(Mem2Reg), 32'd1);
        check("lw_wb_regwrite", 32'(RegWrite), 32'd1);
        check("lw_wb_memread", 32'(MemRead), 32'd0);
        step(); lat++;
        check("lw_latency", 32'(lat), 32'd8);
        check("lw_cnt", instr_cnt, 32'd5);

        // beq taken / not taken, j
        run_branch(32'h1022_0003, 1'b1, 2'b01, 32'd6);
        run_branch(32'h1022_0003, 1'b0, 2'b00, 32'd7);
        run_branch(32'h0800_0010, 1'b0, 2'b10, 32'd8);

        // sw completing immediately
        ins = 32'hAC22_0004;
        step(); step(); step();
        mem_ready = 1'b1;
        #1;
        check("sw_mem_memwrite", 32'(MemWrite), 32'd1);
        check("sw_mem_pcwe", 32'(pc_we), 32'd1);
        step();
        mem_ready = 1'b0;
        check("sw_if_state", 32'(state), 32'd0);
        check("sw_cnt", instr_cnt, 32'd9);

        // sw timeout after WAIT_MAX waits
        ins = 32'hAC22_0004;
        step(); step(); step();
        hi = 0;
        bad = 0;
        for (int k = 0; k < 40 && state != 3'd7; k++) begin
            if (MemWrite) hi++;
            if (pc_we) bad++;
            step();
        end
        check("to_state", 32'(state), 32'd7);
        check("to_memwrite_cycles", 32'(hi), 32'd15);
        check("to_nopcwe", 32'(bad), 32'd0);
        check("to_err", 32'(err), 32'd1);
        check("to_cnt", instr_cnt, 32'd9);
        check("to_strobes", 32'({pc_we, RegWrite, MemRead, MemWrite}), 32'd0);

        // illegal opcode 0x3F
        do_reset();
        ins = 32'hFC00_0000;
        step();
        check("ill_id_state", 32'(state), 32'd1);
        step();
        check("ill_state", 32'(state), 32'd7);
        check("ill_err", 32'(err), 32'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0];
            zero = k[1];
            #1;
            if ({pc_we, RegWrite, MemRead, MemWrite} != 4'd0 || state != 3'd7 || !err) bad++;
            step();
        end
        mem_ready = 1'b0;
        check("ill_hold", 32'(bad), 32'd0);
        do_reset();
        check("ill_rst_state", 32'(state), 32'd0);
        check("ill_rst_err", 32'(err), 32'd0);

        // illegal funct in R-type
        ins = 32'h0022_1821;
        step(); step();
        check("badfunct_state", 32'(state), 32'd7);
        do_reset();

        // sw then reset mid-MEM
        run_alu(32'h0022_1820, 3'b010, 1'b0, 1'b1, 32'd1);
        ins = 32'hAC22_0004;
        step(); step(); step(); step();
        check("rstmem_memwrite_pre", 32'(MemWrite), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmem_memwrite", 32'(MemWrite), 32'd0);
        check("rstmem_pcwe", 32'(pc_we), 32'd0);
        check("rstmem_state", 32'(state), 32'd0);
        check("rstmem_cnt", instr_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmem_rel_state", 32'(state), 32'd0);
        ins = 32'h0022_1820;
        step();
        check("rstmem_next_state", 32'(state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
